// File: rtl/axi_read_data_channel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_data_channel_pkg
//  Description : Shared constants, RRESP codes, FSM state type and clogb2
//                helper for the AXI4 read-data channel consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_read_data_channel_pkg;

  // System-level AXI master configuration
  localparam int C_M_AXI_DATA_WIDTH = 64;
  localparam int C_M_AXI_BURST_LEN  = 16;

  // RRESP encodings
  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  // Receive FSM: either waiting for a burst to be issued or collecting its beats
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rd_state_e;

  // Number of address bits needed to index 'value' entries
  function automatic int clogb2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_read_data_channel_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_data_channel_if
//  Description : AXI4 read-data (R) channel bundle. The master modport is the
//                AXI slave/interconnect side producing beats; the slave modport
//                is the consumer that accepts them.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_read_data_channel_if #(
  parameter int DATA_WIDTH = 64
);

  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output rdata,
    output rresp,
    output rlast,
    output rvalid,
    input  rready
  );

  modport slave (
    input  rdata,
    input  rresp,
    input  rlast,
    input  rvalid,
    output rready
  );

endinterface
`default_nettype wire

// File: rtl/axi_read_data_channel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_data_channel_fifo
//  Description : Synchronous first-word-fall-through FIFO. The head entry is
//                visible on dout whenever empty is low. Pushes while full and
//                pops while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_read_data_channel_fifo
  import axi_read_data_channel_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 64
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    push,
  input  wire logic [DATA_WIDTH-1:0]   din,
  input  wire logic                    pop,
  output logic      [DATA_WIDTH-1:0]   dout,
  output logic                         full,
  output logic                         empty,
  output logic      [clogb2(DEPTH):0]  count
);

  localparam int c_addr_w = clogb2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_addr_w-1:0]   r_wr_ptr;
  logic [c_addr_w-1:0]   r_rd_ptr;
  logic [c_addr_w:0]     r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full   = (r_count == (c_addr_w + 1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];

  // Storage array; no reset needed since entries are only read once valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_addr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_addr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_read_data_channel.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_data_channel
//  Description : AXI4 R-channel consumer. Buffers beats in an FWFT FIFO,
//                presents them as a valid/ready stream, requests a new burst
//                only when a full burst of FIFO space is guaranteed, and
//                flags misplaced RLAST and non-OKAY RRESP (sticky).
//                Optional macro RD_DATA_CHANNEL_STATS_EN adds free-running
//                burst/beat/stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_read_data_channel
  import axi_read_data_channel_pkg::*;
#(
  parameter int DATA_WIDTH = C_M_AXI_DATA_WIDTH,
  parameter int BURST_LEN  = C_M_AXI_BURST_LEN,
  parameter int FIFO_DEPTH = 64
) (
  input  wire logic                  M_AXI_ACLK,
  input  wire logic                  M_AXI_ARESET,
  input  wire logic                  enable,
  input  wire logic                  ar_fire,
  output logic                       rd_en,
  axi_read_data_channel_if.slave     rch,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_valid,
  input  wire logic                  dout_ready,
  output logic                       rlast_err,
  output logic                       rresp_err,
`ifdef RD_DATA_CHANNEL_STATS_EN
  output logic [31:0]                stat_bursts,
  output logic [31:0]                stat_beats,
  output logic [31:0]                stat_stall,
`endif
  output logic                       busy
);

  localparam int c_cnt_w  = clogb2(FIFO_DEPTH) + 1;
  localparam int c_beat_w = clogb2(BURST_LEN);

  rd_state_e             r_state;
  logic [c_beat_w-1:0]   r_beat_cnt;
  logic [c_cnt_w-1:0]    r_reserved;
  logic                  r_rd_en;
  logic                  r_rlast_err;
  logic                  r_rresp_err;

  logic [c_cnt_w-1:0]    w_count;
  logic [c_cnt_w:0]      w_free;
  logic                  w_free_ok;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_beat;
  logic                  w_pop;
  logic                  w_last_slot;
  logic                  w_burst_end;
  logic                  w_resp_bad;

  // Beats are only accepted while collecting a burst and never into a full FIFO
  assign rch.rready  = (r_state == ST_RECV) && !w_full;
  assign w_beat      = rch.rvalid && rch.rready;
  assign w_pop       = dout_valid && dout_ready;
  assign w_last_slot = (r_beat_cnt == c_beat_w'(BURST_LEN - 1));
  // A burst ends on RLAST or, if RLAST is missing, after BURST_LEN beats
  assign w_burst_end = w_beat && (rch.rlast || w_last_slot);
  assign w_resp_bad  = (rch.rresp == RRESP_SLVERR) || (rch.rresp == RRESP_DECERR);

  assign w_free    = (c_cnt_w + 1)'(FIFO_DEPTH) - {1'b0, w_count} - {1'b0, r_reserved};
  assign w_free_ok = (w_free >= (c_cnt_w + 1)'(BURST_LEN));

  assign rd_en      = r_rd_en;
  assign rlast_err  = r_rlast_err;
  assign rresp_err  = r_rresp_err;
  assign dout_valid = !w_empty;
  assign busy       = (r_state != ST_IDLE) || (w_count != '0);

  axi_read_data_channel_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXI_ACLK),
    .rst   (M_AXI_ARESET),
    .push  (w_beat),
    .din   (rch.rdata),
    .pop   (w_pop),
    .dout  (dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Burst FSM with registered burst request and sticky integrity flags
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_rd_en     <= 1'b0;
      r_rlast_err <= 1'b0;
      r_rresp_err <= 1'b0;
    end else begin
      r_rd_en <= enable && w_free_ok && (r_state == ST_IDLE) && !ar_fire;
      case (r_state)
        ST_IDLE: begin
          if (ar_fire) begin
            r_state    <= ST_RECV;
            r_beat_cnt <= '0;
          end
        end
        ST_RECV: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + c_beat_w'(1);
            if (rch.rlast != w_last_slot) begin
              r_rlast_err <= 1'b1;
            end
            if (w_burst_end) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_beat && w_resp_bad) begin
        r_rresp_err <= 1'b1;
      end
    end
  end

  // Space promised to the outstanding burst; released beat by beat and
  // dropped entirely when the burst ends, so an early RLAST cannot leak space
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_reserved <= '0;
    end else if (w_burst_end) begin
      r_reserved <= ar_fire ? c_cnt_w'(BURST_LEN) : '0;
    end else begin
      case ({ar_fire, w_beat})
        2'b10:   r_reserved <= r_reserved + c_cnt_w'(BURST_LEN);
        2'b01:   r_reserved <= r_reserved - c_cnt_w'(1);
        2'b11:   r_reserved <= r_reserved + c_cnt_w'(BURST_LEN - 1);
        default: r_reserved <= r_reserved;
      endcase
    end
  end

`ifdef RD_DATA_CHANNEL_STATS_EN
  // Free-running traffic statistics, wrapping at 2^32
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      stat_bursts <= '0;
      stat_beats  <= '0;
      stat_stall  <= '0;
    end else begin
      if (w_beat && rch.rlast) begin
        stat_bursts <= stat_bursts + 32'd1;
      end
      if (w_beat) begin
        stat_beats <= stat_beats + 32'd1;
      end
      if (rch.rvalid && !rch.rready) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_read_data_channel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_read_data_channel
//  Description : Directed self-checking bench for axi_read_data_channel,
//                ending with a randomized-gap soak against a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_data_channel;
  import axi_read_data_channel_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        ar_fire = 1'b0;
  logic        rd_en;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dir_ready = 1'b0;
  logic        cons_ready = 1'b0;
  logic        dout_ready;
  logic        rlast_err;
  logic        rresp_err;
  logic        busy;
`ifdef RD_DATA_CHANNEL_STATS_EN
  logic [31:0] stat_bursts;
  logic [31:0] stat_beats;
  logic [31:0] stat_stall;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          rnd_mode = 1'b0;
  logic [63:0] sb_q[$];
  int          stall_cycles = 0;
  int          mism = 0;
  int          max_occ = 0;

  always #5 clk = ~clk;

  axi_read_data_channel_if #(.DATA_WIDTH(64)) rch ();

  assign dout_ready = rnd_mode ? cons_ready : dir_ready;

  axi_read_data_channel dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .enable       (enable),
    .ar_fire      (ar_fire),
    .rd_en        (rd_en),
    .rch          (rch),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .rlast_err    (rlast_err),
    .rresp_err    (rresp_err),
`ifdef RD_DATA_CHANNEL_STATS_EN
    .stat_bursts  (stat_bursts),
    .stat_beats   (stat_beats),
    .stat_stall   (stat_stall),
`endif
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable     = 1'b0;
    ar_fire    = 1'b0;
    rch.rvalid = 1'b0;
    rch.rlast  = 1'b0;
    rst        = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rd_en(input int max, output bit ok);
    ok = rd_en;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      ok = rd_en;
    end
  endtask

  task automatic issue_burst(input int max, output bit ok);
    wait_rd_en(max, ok);
    if (ok) begin
      ar_fire = 1'b1;
      tick();
      ar_fire = 1'b0;
    end
  endtask

  // Drives nbeats beats; last_idx marks RLAST, bad_idx gets SLVERR
  task automatic send_burst(input logic [63:0] base, input int nbeats, input int last_idx,
                            input int bad_idx, input bit chk, output bit ok);
    logic [63:0] data;
    int w;
    ok = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      if (rnd_mode) begin
        rch.rvalid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      data = rnd_mode ? {$urandom, $urandom} : base + 64'(i);
      rch.rvalid = 1'b1;
      rch.rdata  = data;
      rch.rlast  = (i == last_idx);
      rch.rresp  = (i == bad_idx) ? RRESP_SLVERR : RRESP_OKAY;
      w = 0;
      while (!rch.rready && w < 300) begin
        tick();
        w++;
        stall_cycles++;
      end
      if (!rch.rready) begin
        ok = 1'b0;
        break;
      end
      if (rnd_mode) sb_q.push_back(data);
      tick();
      if (chk) begin
        check("beat_valid", 64'(dout_valid), 64'd1);
        check("beat_data", dout, data);
      end
    end
    rch.rvalid = 1'b0;
    rch.rlast  = 1'b0;
  endtask

  // Random consumer: decide ready for the coming edge and score the pop
  always @(negedge clk) begin
    if (rnd_mode) begin
      cons_ready = ($urandom_range(0, 3) != 0);
      if (dout_valid && cons_ready) begin
        if (sb_q.size() == 0) mism++;
        else begin
          if (dout !== sb_q[0]) mism++;
          void'(sb_q.pop_front());
        end
      end
      if (sb_q.size() > max_occ) max_occ = sb_q.size();
    end
  end

  initial begin
    bit ok;
    bit ok2;
    int issued;
    int bad;
    int timeouts;

    rch.rvalid = 1'b0;
    rch.rlast  = 1'b0;
    rch.rresp  = RRESP_OKAY;
    rch.rdata  = '0;

    // Reset state
    do_reset();
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_rready", 64'(rch.rready), 64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_rlast_err", 64'(rlast_err), 64'd0);
    check("rst_rresp_err", 64'(rresp_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Request raised within two cycles, dropped after ar_fire
    enable = 1'b1;
    wait_rd_en(2, ok);
    check("t1_rd_en_up", 64'(ok), 64'd1);
    ar_fire = 1'b1;
    tick();
    ar_fire = 1'b0;
    check("t1_rd_en_down", 64'(rd_en), 64'd0);
    check("t1_rready", 64'(rch.rready), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);

    // Full burst streamed straight through
    dir_ready = 1'b1;
    send_burst(64'h1000, 16, 15, -1, 1'b1, ok);
    check("t2_ok", 64'(ok), 64'd1);
    tick();
    check("t2_rlast_err", 64'(rlast_err), 64'd0);
    check("t2_rresp_err", 64'(rresp_err), 64'd0);
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_empty", 64'(dout_valid), 64'd0);

    // Backpressure: only four bursts fit in 64 entries
    dir_ready    = 1'b0;
    stall_cycles = 0;
    issued       = 0;
    for (int a = 0; a < 6; a++) begin
      issue_burst(40, ok);
      if (!ok) break;
      send_burst(64'h3000 + 64'(issued * 16), 16, 15, -1, 1'b0, ok2);
      issued++;
    end
    check("t3_bursts", 64'(issued), 64'd4);
    check("t3_rready_drop", 64'(stall_cycles), 64'd0);
    check("t3_rd_en_low", 64'(rd_en), 64'd0);
    dir_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (!dout_valid || dout !== 64'h3000 + 64'(i)) bad++;
      tick();
    end
    check("t3_drain", 64'(bad), 64'd0);
    tick();
    check("t3_pop_empty", 64'(dout_valid), 64'd0);
    check("t3_busy", 64'(busy), 64'd0);

    // Early RLAST on beat 7
    do_reset();
    enable = 1'b1;
    issue_burst(20, ok);
    send_burst(64'h4000, 8, 7, -1, 1'b1, ok);
    check("t4a_rlast_err", 64'(rlast_err), 64'd1);
    check("t4a_idle", 64'(rch.rready), 64'd0);
    tick();
    check("t4a_busy", 64'(busy), 64'd0);
    wait_rd_en(3, ok);
    check("t4a_rd_en", 64'(ok), 64'd1);
    repeat (3) tick();
    check("t4a_sticky", 64'(rlast_err), 64'd1);

    // Missing RLAST on beat 15, then a late RLAST beat in IDLE
    do_reset();
    enable = 1'b1;
    issue_burst(20, ok);
    send_burst(64'h4100, 16, -1, -1, 1'b1, ok);
    check("t4b_rlast_err", 64'(rlast_err), 64'd1);
    check("t4b_idle", 64'(rch.rready), 64'd0);
    wait_rd_en(3, ok);
    check("t4b_rd_en", 64'(ok), 64'd1);
    enable     = 1'b0;
    tick();
    rch.rvalid = 1'b1;
    rch.rlast  = 1'b1;
    rch.rdata  = 64'hDEAD;
    repeat (3) tick();
    check("t4b_late_rready", 64'(rch.rready), 64'd0);
    check("t4b_late_dropped", 64'(dout_valid), 64'd0);
    rch.rvalid = 1'b0;
    rch.rlast  = 1'b0;

    // SLVERR on beat 3: flagged, data delivered, cleared by reset
    do_reset();
    enable = 1'b1;
    issue_burst(20, ok);
    send_burst(64'h5000, 16, 15, 3, 1'b1, ok);
    check("t5_rresp_err", 64'(rresp_err), 64'd1);
    check("t5_rlast_err", 64'(rlast_err), 64'd0);
    do_reset();
    check("t5_cleared", 64'(rresp_err), 64'd0);

    // Random gaps on both sides over 1000 bursts
    enable       = 1'b1;
    rnd_mode     = 1'b1;
    mism         = 0;
    max_occ      = 0;
    timeouts     = 0;
    for (int b = 0; b < 1000; b++) begin
      issue_burst(500, ok);
      if (!ok) begin
        timeouts++;
        break;
      end
      send_burst(64'h0, 16, 15, -1, 1'b0, ok);
      if (!ok) begin
        timeouts++;
        break;
      end
    end
    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) tick();
    tick();
    rnd_mode = 1'b0;
    check("t6_timeouts", 64'(timeouts), 64'd0);
    check("t6_mismatch", 64'(mism), 64'd0);
    check("t6_drained", 64'(sb_q.size()), 64'd0);
    check("t6_occ_le_64", 64'(max_occ <= 64), 64'd1);
    check("t6_errs", 64'({rlast_err, rresp_err}), 64'd0);
`ifdef RD_DATA_CHANNEL_STATS_EN
    check("t6_stat_beats", 64'(stat_beats), 64'd16000);
    check("t6_stat_bursts", 64'(stat_bursts), 64'd1000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
